// File: rtl/combo_lock_ctrl.sv
// combo_lock_ctrl: switch-tap combination lock with programmable code and
// failure lockout. Raw switch/button inputs are synchronized, converted to
// single tap / program events, and fed to a five-state controller.
module combo_lock_ctrl #(
   parameter int CODE_LEN    = 4,
   parameter int MAX_FAIL    = 3,
   parameter int LOCK_CYCLES = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] sw,
   input  logic       prog,
   output logic [1:0] led,
   output logic       unlocked,
   output logic       locked_out
);

   localparam int IDX_W = (CODE_LEN > 1) ? $clog2(CODE_LEN) : 1;
   localparam int LCW   = $clog2(LOCK_CYCLES);
   localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(CODE_LEN - 1);
   localparam logic [3:0]       FAIL_LIMIT = 4'(MAX_FAIL);
   localparam logic [LCW-1:0]   LOCK_LOAD  = LCW'(LOCK_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ENTER,
      S_OPEN,
      S_PROG,
      S_LOCKOUT
   } state_t;

   // Input synchronizers plus one extra delay stage for edge detection
   logic [3:0] sw_meta_q, sw_meta_d;
   logic [3:0] sw_s_q, sw_s_d;
   logic [3:0] sw_dly_q, sw_dly_d;
   logic       prog_meta_q, prog_meta_d;
   logic       prog_s_q, prog_s_d;
   logic       prog_dly_q, prog_dly_d;

   // Controller state
   state_t           state_q, state_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic             mismatch_q, mismatch_d;
   logic [3:0]       fail_cnt_q, fail_cnt_d;
   logic [LCW-1:0]   lock_cnt_q, lock_cnt_d;
   logic [3:0]       code_q [CODE_LEN];
   logic [3:0]       code_d [CODE_LEN];

   logic tap;
   logic prog_evt;
   logic idle_miss;
   logic step_miss;
   logic eval_now;
   logic eval_miss;

   // Synchronizer chain next values
   always_comb begin
      sw_meta_d   = sw;
      sw_s_d      = sw_meta_q;
      sw_dly_d    = sw_s_q;
      prog_meta_d = prog;
      prog_s_d    = prog_meta_q;
      prog_dly_d  = prog_s_q;
   end

   // Synchronizer and delay registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sw_meta_q   <= '0;
         sw_s_q      <= '0;
         sw_dly_q    <= '0;
         prog_meta_q <= 1'b0;
         prog_s_q    <= 1'b0;
         prog_dly_q  <= 1'b0;
      end else begin
         sw_meta_q   <= sw_meta_d;
         sw_s_q      <= sw_s_d;
         sw_dly_q    <= sw_dly_d;
         prog_meta_q <= prog_meta_d;
         prog_s_q    <= prog_s_d;
         prog_dly_q  <= prog_dly_d;
      end
   end

   // A tap is the first nonzero value after all-zero; prog is rising-edge only
   assign tap       = (sw_dly_q == 4'd0) && (sw_s_q != 4'd0);
   assign prog_evt  = prog_s_q && !prog_dly_q;
   assign idle_miss = (sw_s_q != code_q[0]);
   assign step_miss = (sw_s_q != code_q[idx_q]);

   // Next-state, step index, attempt bookkeeping and code writes
   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      mismatch_d = mismatch_q;
      fail_cnt_d = fail_cnt_q;
      lock_cnt_d = lock_cnt_q;
      code_d     = code_q;
      eval_now   = 1'b0;
      eval_miss  = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (tap) begin
               if (CODE_LEN == 1) begin
                  eval_now  = 1'b1;
                  eval_miss = idle_miss;
               end else begin
                  mismatch_d = idle_miss;
                  idx_d      = IDX_W'(1);
                  state_d    = S_ENTER;
               end
            end
         end
         S_ENTER: begin
            if (tap) begin
               if (idx_q == LAST_IDX) begin
                  eval_now  = 1'b1;
                  eval_miss = mismatch_q | step_miss;
               end else begin
                  mismatch_d = mismatch_q | step_miss;
                  idx_d      = idx_q + IDX_W'(1);
               end
            end
         end
         S_OPEN: begin
            // prog takes priority over a coincident relock tap
            if (prog_evt) begin
               idx_d   = '0;
               state_d = S_PROG;
            end else if (tap) begin
               state_d = S_IDLE;
            end
         end
         S_PROG: begin
            if (prog_evt) begin
               idx_d   = '0;
               state_d = S_OPEN;
            end else if (tap) begin
               code_d[idx_q] = sw_s_q;
               if (idx_q == LAST_IDX) begin
                  idx_d   = '0;
                  state_d = S_IDLE;
               end else begin
                  idx_d = idx_q + IDX_W'(1);
               end
            end
         end
         S_LOCKOUT: begin
            if (lock_cnt_q == '0) begin
               state_d = S_IDLE;
            end else begin
               lock_cnt_d = lock_cnt_q - LCW'(1);
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Attempt evaluation once the final step has been compared
      if (eval_now) begin
         idx_d      = '0;
         mismatch_d = 1'b0;
         if (!eval_miss) begin
            fail_cnt_d = '0;
            state_d    = S_OPEN;
         end else if (fail_cnt_q + 4'd1 == FAIL_LIMIT) begin
            fail_cnt_d = '0;
            lock_cnt_d = LOCK_LOAD;
            state_d    = S_LOCKOUT;
         end else begin
            fail_cnt_d = fail_cnt_q + 4'd1;
            state_d    = S_IDLE;
         end
      end
   end

   // Controller and code-store registers; code resets to one-hot defaults
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= S_IDLE;
         idx_q      <= '0;
         mismatch_q <= 1'b0;
         fail_cnt_q <= '0;
         lock_cnt_q <= '0;
         for (int i = 0; i < CODE_LEN; i++) begin
            code_q[i] <= 4'(1 << (i % 4));
         end
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         mismatch_q <= mismatch_d;
         fail_cnt_q <= fail_cnt_d;
         lock_cnt_q <= lock_cnt_d;
         for (int i = 0; i < CODE_LEN; i++) begin
            code_q[i] <= code_d[i];
         end
      end
   end

   // Status outputs decode directly from the state register
   always_comb begin
      led        = 2'b01;
      unlocked   = 1'b0;
      locked_out = 1'b0;
      case (state_q)
         S_IDLE:    led = 2'b01;
         S_ENTER:   led = 2'b10;
         S_PROG:    led = 2'b10;
         S_OPEN: begin
            led      = 2'b11;
            unlocked = 1'b1;
         end
         S_LOCKOUT: begin
            led        = 2'b00;
            locked_out = 1'b1;
         end
         default:   led = 2'b01;
      endcase
   end

endmodule

// File: tb/tb_combo_lock_ctrl.sv
// Directed bench for combo_lock_ctrl. Expected status words
// {led, unlocked, locked_out} are queued when stimulus is driven and
// popped when the DUT output is sampled.
module tb_combo_lock_ctrl;

   localparam logic [3:0] ST_IDLE = 4'b0100;
   localparam logic [3:0] ST_ENT  = 4'b1000;
   localparam logic [3:0] ST_PROG = 4'b1000;
   localparam logic [3:0] ST_OPEN = 4'b1110;
   localparam logic [3:0] ST_LOCK = 4'b0001;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] sw;
   logic       prog;
   logic [1:0] led;
   logic       unlocked;
   logic       locked_out;
   logic [3:0] status;

   int         n_checks = 0;
   int         n_fail   = 0;
   logic [3:0] sb [$];
   logic [3:0] cur;
   int         n_lock;

   combo_lock_ctrl #(
      .CODE_LEN   (4),
      .MAX_FAIL   (3),
      .LOCK_CYCLES(16)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .sw        (sw),
      .prog      (prog),
      .led       (led),
      .unlocked  (unlocked),
      .locked_out(locked_out)
   );

   always #5 clk = ~clk;

   assign status = {led, unlocked, locked_out};

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic chk_int(input string tag, input int obs, input int exp);
      n_checks++;
      assert (obs == exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic sb_check(input string tag);
      if (sb.size() == 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL %s: scoreboard empty, observed %b", tag, status);
      end else begin
         chk(tag, status, sb.pop_front());
      end
   endtask

   // Drive a level, verify no change one edge early, then the new state
   task automatic drive_nohold(input logic [3:0] v_sw, input logic v_prog,
                               input logic [3:0] exp, input string tag);
      @(negedge clk);
      sw   = v_sw;
      prog = v_prog;
      sb.push_back(cur);
      sb.push_back(exp);
      @(posedge clk);
      @(posedge clk);
      #1 sb_check({tag, "_early"});
      @(posedge clk);
      #1 sb_check(tag);
      cur = exp;
   endtask

   // Full step: drive, then return inputs to zero and confirm state holds
   task automatic drive(input logic [3:0] v_sw, input logic v_prog,
                        input logic [3:0] exp, input string tag);
      drive_nohold(v_sw, v_prog, exp, tag);
      @(negedge clk);
      sw   = 4'd0;
      prog = 1'b0;
      sb.push_back(cur);
      repeat (3) @(posedge clk);
      #1 sb_check({tag, "_hold"});
   endtask

   task automatic do_reset(input string tag);
      @(negedge clk);
      #2 rst = 1'b0;
      sw   = 4'd0;
      prog = 1'b0;
      #1;
      sb.push_back(ST_IDLE);
      sb_check(tag);
      cur = ST_IDLE;
      #14 rst = 1'b1;
      repeat (4) @(posedge clk);
      #1;
   endtask

   initial begin
      rst  = 1'b1;
      sw   = 4'd0;
      prog = 1'b0;
      cur  = ST_IDLE;
      #3 rst = 1'b0;
      #2;
      sb.push_back(ST_IDLE);
      sb_check("reset_state");
      #20 rst = 1'b1;
      repeat (4) @(posedge clk);

      // Default code unlocks, any tap relocks
      drive(4'b0001, 1'b0, ST_ENT,  "def_t1");
      drive(4'b0010, 1'b0, ST_ENT,  "def_t2");
      drive(4'b0100, 1'b0, ST_ENT,  "def_t3");
      drive(4'b1000, 1'b0, ST_OPEN, "def_t4");
      drive(4'b0011, 1'b0, ST_IDLE, "relock1");

      // Three wrong attempts in a row lead to lockout
      drive(4'b0001, 1'b0, ST_ENT,  "wr1_t1");
      drive(4'b0001, 1'b0, ST_ENT,  "wr1_t2");
      drive(4'b0100, 1'b0, ST_ENT,  "wr1_t3");
      drive(4'b1000, 1'b0, ST_IDLE, "wr1_t4");
      drive(4'b1000, 1'b0, ST_ENT,  "wr2_t1");
      drive(4'b0010, 1'b0, ST_ENT,  "wr2_t2");
      drive(4'b0100, 1'b0, ST_ENT,  "wr2_t3");
      drive(4'b1000, 1'b0, ST_IDLE, "wr2_t4");
      drive(4'b0001, 1'b0, ST_ENT,  "wr3_t1");
      drive(4'b0010, 1'b0, ST_ENT,  "wr3_t2");
      drive(4'b0100, 1'b0, ST_ENT,  "wr3_t3");
      drive_nohold(4'b0100, 1'b0, ST_LOCK, "wr3_t4");

      // Lockout length, with taps of the first code digit thrown at it
      n_lock = 1;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         sw = (k < 10 && (k % 2) == 1) ? 4'b0001 : 4'b0000;
         @(posedge clk);
         #1;
         if (locked_out !== 1'b1) break;
         n_lock++;
      end
      chk_int("lockout_cycles", n_lock, 16);
      sb.push_back(ST_IDLE);
      sb_check("lockout_exit");
      cur = ST_IDLE;
      repeat (3) @(posedge clk);
      #1;

      drive(4'b0001, 1'b0, ST_ENT,  "post_t1");
      drive(4'b0010, 1'b0, ST_ENT,  "post_t2");
      drive(4'b0100, 1'b0, ST_ENT,  "post_t3");
      drive(4'b1000, 1'b0, ST_OPEN, "post_t4");

      // Program 1000,1000,0010,0001
      drive(4'b0000, 1'b1, ST_PROG, "prog_enter");
      drive(4'b1000, 1'b0, ST_PROG, "pw_t1");
      drive(4'b1000, 1'b0, ST_PROG, "pw_t2");
      drive(4'b0010, 1'b0, ST_PROG, "pw_t3");
      drive(4'b0001, 1'b0, ST_IDLE, "pw_t4");

      // Old default now fails, new code opens
      drive(4'b0001, 1'b0, ST_ENT,  "old_t1");
      drive(4'b0010, 1'b0, ST_ENT,  "old_t2");
      drive(4'b0100, 1'b0, ST_ENT,  "old_t3");
      drive(4'b1000, 1'b0, ST_IDLE, "old_t4");
      drive(4'b1000, 1'b0, ST_ENT,  "new_t1");
      drive(4'b1000, 1'b0, ST_ENT,  "new_t2");
      drive(4'b0010, 1'b0, ST_ENT,  "new_t3");
      drive(4'b0001, 1'b0, ST_OPEN, "new_t4");
      drive(4'b0100, 1'b0, ST_IDLE, "relock2");

      // Held switch counts as a single tap
      @(negedge clk);
      sw = 4'b0011;
      sb.push_back(ST_IDLE);
      sb.push_back(ST_ENT);
      repeat (2) @(posedge clk);
      #1 sb_check("held_early");
      repeat (18) @(posedge clk);
      #1 sb_check("held_20cyc");
      cur = ST_ENT;
      @(negedge clk);
      sw = 4'd0;
      repeat (3) @(posedge clk);
      drive(4'b1000, 1'b0, ST_ENT,  "held_t2");
      drive(4'b0010, 1'b0, ST_ENT,  "held_t3");
      drive(4'b0001, 1'b0, ST_IDLE, "held_t4");

      // prog and tap together in OPEN enter PROG; prog abort keeps partial code
      drive(4'b1000, 1'b0, ST_ENT,  "nc_t1");
      drive(4'b1000, 1'b0, ST_ENT,  "nc_t2");
      drive(4'b0010, 1'b0, ST_ENT,  "nc_t3");
      drive(4'b0001, 1'b0, ST_OPEN, "nc_t4");
      drive(4'b0100, 1'b1, ST_PROG, "prog_and_tap");
      drive(4'b0001, 1'b0, ST_PROG, "abort_w1");
      drive(4'b0000, 1'b1, ST_OPEN, "prog_abort");
      drive(4'b1000, 1'b0, ST_IDLE, "relock3");
      drive(4'b0001, 1'b0, ST_ENT,  "part_t1");
      drive(4'b1000, 1'b0, ST_ENT,  "part_t2");
      drive(4'b0010, 1'b0, ST_ENT,  "part_t3");
      drive(4'b0001, 1'b0, ST_OPEN, "part_t4");

      // Reset in the middle of programming restores the default code
      drive(4'b0000, 1'b1, ST_PROG, "prog_enter2");
      drive(4'b0100, 1'b0, ST_PROG, "rp_t1");
      drive(4'b0100, 1'b0, ST_PROG, "rp_t2");
      do_reset("reset_mid_prog");
      drive(4'b0001, 1'b0, ST_ENT,  "rd_t1");
      drive(4'b0010, 1'b0, ST_ENT,  "rd_t2");
      drive(4'b0100, 1'b0, ST_ENT,  "rd_t3");
      drive(4'b1000, 1'b0, ST_OPEN, "rd_t4");

      if (sb.size() != 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL sb_drain: %0d entries left, expected 0", sb.size());
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
